// File: rtl/tconvert_avg.sv
// Streaming temperature converter: box-car averages 2^AVG_LOG2 signed Celsius samples,
// converts each window average to x10 C/F/K and tracks the running min/max average.
module tconvert_avg #(
  parameter  int WIDTH    = 13,
  parameter  int AVG_LOG2 = 2,
  localparam int OUT_W    = WIDTH + 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tc,
  input  logic             tc_valid,
  input  logic [1:0]       mode,
  input  logic             clr_minmax,
  output logic [OUT_W-1:0] tx,
  output logic             tx_valid,
  output logic [WIDTH-1:0] min_tc,
  output logic [WIDTH-1:0] max_tc,
  output logic             minmax_valid
);

  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  localparam logic signed [OUT_W-1:0] MUL10 = OUT_W'(10);
  localparam logic signed [OUT_W-1:0] MUL18 = OUT_W'(18);
  localparam logic signed [OUT_W-1:0] F_OFS = OUT_W'(5120);   // 320 F x16
  localparam logic signed [OUT_W-1:0] K_OFS = OUT_W'(43704);  // 273.15 K x160

  localparam logic signed [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [1:0]              r_mode_q;
  logic                    r_s1_valid;
  logic signed [WIDTH-1:0] r_s1_avg;
  logic [1:0]              r_s1_mode;
  logic signed [OUT_W-1:0] r_tx;
  logic                    r_tx_valid;
  logic signed [WIDTH-1:0] r_min;
  logic signed [WIDTH-1:0] r_max;
  logic                    r_mm_valid;

  logic signed [ACC_W-1:0] w_tc_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [WIDTH-1:0] w_avg;
  logic                    w_first;
  logic                    w_close;
  logic [1:0]              w_win_mode;
  logic signed [OUT_W-1:0] w_avg_ext;
  logic signed [OUT_W-1:0] w_conv;

  assign w_tc_ext   = ACC_W'($signed(tc));
  assign w_first    = (r_cnt == '0);
  // The first sample of a window overwrites the accumulator, so no separate clear cycle is needed.
  assign w_sum      = w_first ? w_tc_ext : (r_acc + w_tc_ext);
  assign w_avg      = WIDTH'(w_sum >>> AVG_LOG2);
  assign w_close    = tc_valid && (r_cnt == LAST_CNT);
  assign w_win_mode = w_first ? mode : r_mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_mode_q   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_avg   <= '0;
      r_s1_mode  <= '0;
    end else begin
      r_s1_valid <= w_close;
      if (tc_valid) begin
        r_acc <= w_sum;
        r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
        if (w_first) r_mode_q <= mode;
      end
      if (w_close) begin
        r_s1_avg  <= w_avg;
        r_s1_mode <= w_win_mode;
      end
    end
  end

  assign w_avg_ext = OUT_W'(r_s1_avg);

  always_comb begin
    w_conv = w_avg_ext * MUL10;
    case (r_s1_mode)
      2'd1:    w_conv = (w_avg_ext * MUL18) + F_OFS;
      2'd2:    w_conv = (w_avg_ext * MUL10) + K_OFS;
      default: w_conv = w_avg_ext * MUL10;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx       <= '0;
      r_tx_valid <= 1'b0;
      r_min      <= MOST_POS;
      r_max      <= MOST_NEG;
      r_mm_valid <= 1'b0;
    end else begin
      r_tx_valid <= r_s1_valid;
      if (r_s1_valid) r_tx <= w_conv;
      // A result arriving together with a clear seeds the tracker fresh from that result.
      if (r_s1_valid && clr_minmax) begin
        r_min      <= r_s1_avg;
        r_max      <= r_s1_avg;
        r_mm_valid <= 1'b1;
      end else if (r_s1_valid) begin
        if (r_s1_avg < r_min) r_min <= r_s1_avg;
        if (r_s1_avg > r_max) r_max <= r_s1_avg;
        r_mm_valid <= 1'b1;
      end else if (clr_minmax) begin
        r_min      <= MOST_POS;
        r_max      <= MOST_NEG;
        r_mm_valid <= 1'b0;
      end
    end
  end

  assign tx           = r_tx;
  assign tx_valid     = r_tx_valid;
  assign min_tc       = r_min;
  assign max_tc       = r_max;
  assign minmax_valid = r_mm_valid;

endmodule

// File: tb/tb_tconvert_avg.sv
// Bench for tconvert_avg: vector table, hand-written corner sequences and random windows
// checked against an arithmetic model of averaging, conversion and min/max tracking.
module tb_tconvert_avg;

  localparam int WIDTH = 13;
  localparam int OUT_W = WIDTH + 5;
  localparam int N     = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] tc;
  logic             tc_valid;
  logic [1:0]       mode;
  logic             clr_minmax;
  logic [OUT_W-1:0] tx;
  logic             tx_valid;
  logic [WIDTH-1:0] min_tc;
  logic [WIDTH-1:0] max_tc;
  logic             minmax_valid;

  tconvert_avg #(.WIDTH(WIDTH), .AVG_LOG2(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .tc           (tc),
    .tc_valid     (tc_valid),
    .mode         (mode),
    .clr_minmax   (clr_minmax),
    .tx           (tx),
    .tx_valid     (tx_valid),
    .min_tc       (min_tc),
    .max_tc       (max_tc),
    .minmax_valid (minmax_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [OUT_W-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_min_q[$];
  logic [WIDTH-1:0] exp_max_q[$];

  int win_sum, win_n, win_mode;
  int mm_min, mm_max;
  bit seed_mm, use_tab;
  int tab_tx;

  typedef struct {
    int s[4];
    int m[4];
    int exp_tx;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int floor_div(input int s, input int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  function automatic int conv(input int avg, input int m);
    case (m)
      1:       return avg * 18 + 5120;
      2:       return avg * 10 + 43704;
      default: return avg * 10;
    endcase
  endfunction

  task automatic model_reset();
    win_sum = 0;
    win_n   = 0;
    mm_min  = 4095;
    mm_max  = -4096;
    seed_mm = 1'b0;
  endtask

  task automatic push_result(input int avg, input int m);
    if (seed_mm) begin
      mm_min  = avg;
      mm_max  = avg;
      seed_mm = 1'b0;
    end else begin
      if (avg < mm_min) mm_min = avg;
      if (avg > mm_max) mm_max = avg;
    end
    exp_q.push_back(OUT_W'(use_tab ? tab_tx : conv(avg, m)));
    exp_min_q.push_back(WIDTH'(mm_min));
    exp_max_q.push_back(WIDTH'(mm_max));
  endtask

  // driver tasks
  task automatic send(input int t, input int m);
    @(negedge clk);
    tc       = WIDTH'(t);
    mode     = 2'(m);
    tc_valid = 1'b1;
    if (win_n == 0) win_mode = m;
    win_sum += t;
    win_n++;
    if (win_n == N) begin
      push_result(floor_div(win_sum, N), win_mode);
      win_sum = 0;
      win_n   = 0;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      tc_valid = 1'b0;
      mode     = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    tc_valid   = 1'b0;
    clr_minmax = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic set_vec(input int i, input int s0, input int s1, input int s2, input int s3,
                         input int m0, input int m1, input int m2, input int m3, input int e);
    vecs[i].s[0] = s0; vecs[i].s[1] = s1; vecs[i].s[2] = s2; vecs[i].s[3] = s3;
    vecs[i].m[0] = m0; vecs[i].m[1] = m1; vecs[i].m[2] = m2; vecs[i].m[3] = m3;
    vecs[i].exp_tx = e;
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rst && tx_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_tx_valid", int'(tx_valid), 0);
      end else begin
        logic [OUT_W-1:0] e_tx;
        logic [WIDTH-1:0] e_min, e_max;
        e_tx  = exp_q.pop_front();
        e_min = exp_min_q.pop_front();
        e_max = exp_max_q.pop_front();
        check("tx", $signed(tx), $signed(e_tx));
        check("min_tc", $signed(min_tc), $signed(e_min));
        check("max_tc", $signed(max_tc), $signed(e_max));
        check("minmax_valid", int'(minmax_valid), 1);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    tc         = '0;
    tc_valid   = 1'b0;
    mode       = 2'd0;
    clr_minmax = 1'b0;
    use_tab    = 1'b0;
    tab_tx     = 0;
    win_mode   = 0;
    model_reset();

    set_vec(0,   400,   400,   400,   400, 1, 1, 1, 1, 12320);
    set_vec(1,   400,   400,   400,   400, 2, 2, 2, 2, 47704);
    set_vec(2,    -1,    -2,    -1,    -2, 0, 0, 0, 0, -20);
    set_vec(3,   400,   400,   400,   400, 0, 0, 0, 0, 4000);
    set_vec(4,   400,   400,   400,   400, 0, 0, 1, 1, 4000);
    set_vec(5,   400,   400,   400,   400, 1, 0, 0, 0, 12320);
    set_vec(6, -4096, -4096, -4096, -4096, 1, 1, 1, 1, -68608);
    set_vec(7,  4095,  4095,  4095,  4095, 2, 2, 2, 2, 84654);
    set_vec(8,   100,   101,   102,   103, 3, 3, 3, 3, 1010);
    set_vec(9,    -7,     5,    -9,     2, 0, 2, 2, 1, -30);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_tx", $signed(tx), 0);
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_min", $signed(min_tc), 4095);
    check("rst_max", $signed(max_tc), -4096);
    check("rst_mmv", int'(minmax_valid), 0);

    // latency: 4th sample accepted at edge N, result visible after edge N+1
    for (int i = 0; i < N; i++) send(400, 0);
    @(posedge clk);
    #1;
    tc_valid = 1'b0;
    check("latency_early", int'(tx_valid), 0);
    @(posedge clk);
    #1;
    check("latency_valid", int'(tx_valid), 1);
    check("latency_tx", $signed(tx), 4000);
    @(posedge clk);
    #1;
    check("pulse_width", int'(tx_valid), 0);
    check("tx_hold", $signed(tx), 4000);
    drain();

    // table vectors, with a few gap cycles inside some windows
    use_tab = 1'b1;
    for (int v = 0; v < 10; v++) begin
      tab_tx = vecs[v].exp_tx;
      for (int k = 0; k < N; k++) begin
        send(vecs[v].s[k], vecs[v].m[k]);
        if (v % 3 == 1) idle(k % 2 + 1);
      end
      if (v == 3) begin
        drain();
        check("min_neg_avg", $signed(min_tc), -2);
        check("max_after_400", $signed(max_tc), 400);
      end
    end
    drain();
    use_tab = 1'b0;
    check("min_full_scale", $signed(min_tc), -4096);
    check("max_full_scale", $signed(max_tc), 4095);

    // reset mid-window, then clear on the same edge as a result
    do_reset();
    send(999, 2);
    send(999, 2);
    do_reset();
    check("rst_mid_mmv", int'(minmax_valid), 0);
    for (int i = 0; i < N; i++) send(800, 0);
    drain();
    for (int i = 0; i < N - 1; i++) send(160, 0);
    seed_mm = 1'b1;
    send(160, 0);
    @(negedge clk);
    tc_valid   = 1'b0;
    clr_minmax = 1'b1;
    @(negedge clk);
    clr_minmax = 1'b0;
    check("clr_with_update_min", $signed(min_tc), 160);
    check("clr_with_update_max", $signed(max_tc), 160);
    drain();

    // clear alone
    @(negedge clk);
    clr_minmax = 1'b1;
    @(negedge clk);
    clr_minmax = 1'b0;
    model_reset();
    check("clr_min", $signed(min_tc), 4095);
    check("clr_max", $signed(max_tc), -4096);
    check("clr_mmv", int'(minmax_valid), 0);

    // random windows with random modes and gaps
    for (int w = 0; w < 60; w++) begin
      for (int k = 0; k < N; k++) begin
        send(int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
